app_flit_injector: RTL
======================

// Module: app_flit_injector
// PURPOSE
//  Synthesizable packet injector feeding the many-core app_src port (rx/credit/data) with credit-based flow control.
//  A host or loader pushes raw flits through a valid/ready port into an internal FIFO.
//  An FSM parses the flits as packets [header, size N, N payload flits] and tracks packet boundaries.
//  en_i gates injection only at packet boundaries, so a packet is never split on the NoC.
// PARAMETERS
//  FLIT_SIZE     32  flit width in bits; also the width of the size field
//  BUFFER_DEPTH  8   FIFO depth in flits; must be a power of two, >= 2
// PORTS
//  clk_i          in   1          clock; all logic on the rising edge
//  rst_ni         in   1          reset, synchronous, active-low
//  en_i           in   1          injection enable; sampled only at packet boundaries
//  src_valid_i    in   1          host flit valid
//  src_ready_o    out  1          FIFO can accept a flit (= !full)
//  src_data_i     in   FLIT_SIZE  host flit
//  tx_o           out  1          flit valid toward the NoC (drives app_src_rx_i)
//  credit_i       in   1          NoC can accept a flit (from app_src_credit_o)
//  data_o         out  FLIT_SIZE  flit toward the NoC, equal to the FIFO head
//  busy_o         out  1          high when state != S_HEADER or the FIFO is not empty
//  pkt_done_o     out  1          one-cycle pulse after the last flit of a packet is accepted
// BEHAVIOUR
//  Reset (rst_ni=0 at a clock edge)
//   - Outputs: tx_o=0, src_ready_o=0, pkt_done_o=0, busy_o=0, data_o=0.
//   - FIFO is emptied; state=S_HEADER; remaining-flit counter rem=0.
//   - src_ready_o rises in the first cycle after reset is released.
//   - Reset mid-packet drops all buffered flits; the partial packet is not completed.
//  Push and pop
//   - push = src_valid_i && src_ready_o.
//   - pop (accept) = tx_o && credit_i.
//   - Flit ordering is strictly FIFO.
//   - A flit pushed in cycle t can be presented on tx_o/data_o in cycle t+1 at the earliest.
//   - FIFO pointers are clog2(BUFFER_DEPTH)+1 bits wide and wrap naturally.
//   - full when the pointers differ only in the MSB; empty when they are equal.
//   - Push and pop in the same cycle: the count is unchanged. Allowed when full, since the pop frees a slot.
//   - src_ready_o is derived from the registered count. A same-cycle pop does not raise ready combinationally.
//  NoC handshake
//   - tx_o = !empty && (state != S_HEADER || en_i).
//   - data_o and tx_o are held stable while tx_o=1 and credit_i=0.
//   - credit_i=0 for any number of cycles stalls without loss.
//  FSM (advances on pop only)
//   - S_HEADER: on pop -> S_SIZE.
//   - S_SIZE: on pop with data_o==0 -> S_HEADER and pkt_done_o=1 next cycle.
//   - S_SIZE: on pop with data_o!=0 -> rem=data_o, go to S_PAYLOAD.
//   - S_PAYLOAD: on pop, rem=rem-1.
//   - S_PAYLOAD: if rem==1 at the pop -> S_HEADER and pkt_done_o=1 next cycle.
//   - rem is FLIT_SIZE wide and unsigned. A size of 2^FLIT_SIZE-1 is legal; rem never underflows.
//  en_i
//   - en_i=0 in S_HEADER: tx_o=0 and flits accumulate until full.
//   - en_i=0 mid-packet: ignored; the packet completes.
//   - Back-to-back packets need no idle cycle: a header can be accepted in the cycle after the last payload flit.
// CONFIGURATION
//  APP_INJ_STATS_EN defined: adds two outputs.
//   - pkt_count_o  out 32: packets completed; +1 per pkt_done_o.
//   - flit_count_o out 32: flits accepted; +1 per pop.
//   - Both reset to 0 and wrap modulo 2^32.
//  APP_INJ_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.
// TESTING
//  T1 Single packet, credit_i=1, en_i=1
//   - Push 0x0101, 3, A, B, C -> tx_o high for 5 consecutive cycles, data_o = 0x0101,3,A,B,C.
//   - pkt_done_o pulses once, one cycle after C is accepted.
//  T2 Credit stall
//   - As T1 with credit_i=0 for 4 cycles while data_o=A -> data_o stays A, tx_o stays 1.
//   - No flit lost or duplicated; output order is unchanged.
//  T3 Full FIFO
//   - en_i=0, push 9 flits -> src_ready_o=0 after 8 pushes.
//   - The 9th flit is held by the host and enters only after en_i=1 and the first pop.
//  T4 Zero-size packet and back-to-back
//   - Push [H1,0],[H2,1,X] -> pkt_done_o pulses after 0 is accepted and after X is accepted.
//   - H2 is accepted in the cycle after 0.
//  T5 Mid-packet disable and reset
//   - en_i=0 after the size flit of size 2 -> both payload flits are still sent, then tx_o=0.
//   - Separate run: rst_ni=0 mid-payload -> tx_o=0 and busy_o=0 the next cycle; a new packet works afterwards.
//  T6 Stats (APP_INJ_STATS_EN)
//   - Run T1 then T4 -> pkt_count_o=3, flit_count_o=10.

Source files
------------

// File: rtl/app_flit_injector.sv
// Credit-based packet injector: buffers host flits in a FIFO and releases them to the NoC only on packet boundaries.
// Optional statistics counters are enabled by defining APP_INJ_STATS_EN.
module app_flit_injector #(
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [FLIT_SIZE-1:0] src_data_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 busy_o,
    output logic                 pkt_done_o
`ifdef APP_INJ_STATS_EN
    ,
    output logic [31:0]          pkt_count_o,
    output logic [31:0]          flit_count_o
`endif
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    localparam logic [1:0] S_HEADER  = 2'd0;
    localparam logic [1:0] S_SIZE    = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    logic [FLIT_SIZE-1:0] mem [BUFFER_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [1:0]           state;
    logic [FLIT_SIZE-1:0] rem;
    logic                 ready_en;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // ready_en keeps the host port closed during reset and for the reset cycle itself
    assign src_ready_o = ready_en && !full;
    assign push        = src_valid_i && src_ready_o;
    assign tx_o        = !empty && ((state != S_HEADER) || en_i);
    assign pop         = tx_o && credit_i;
    assign data_o      = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign busy_o      = (state != S_HEADER) || !empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= src_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= S_HEADER;
            rem        <= '0;
            pkt_done_o <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            pkt_done_o <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                case (state)
                    S_HEADER: begin
                        state <= S_SIZE;
                    end
                    S_SIZE: begin
                        if (data_o == '0) begin
                            state      <= S_HEADER;
                            pkt_done_o <= 1'b1;
                        end else begin
                            rem   <= data_o;
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        rem <= rem - FLIT_SIZE'(1);
                        if (rem == FLIT_SIZE'(1)) begin
                            state      <= S_HEADER;
                            pkt_done_o <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_HEADER;
                    end
                endcase
            end
        end
    end

`ifdef APP_INJ_STATS_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pkt_count_o  <= '0;
            flit_count_o <= '0;
        end else begin
            if (pkt_done_o) begin
                pkt_count_o <= pkt_count_o + 32'd1;
            end
            if (pop) begin
                flit_count_o <= flit_count_o + 32'd1;
            end
        end
    end
`endif

endmodule
